// File: rtl/jt10_adpcma_rom_pkg.sv
// Shared types and widths for the ADPCM-A ROM responder and its tag CAM.
package jt10_adpcma_rom_pkg;

    localparam int KEY_W  = 24;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ_D = 2'd1,
        REQ_P = 2'd2
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [KEY_W-1:0] key;
    } slot_t;

endpackage

// File: rtl/jt10_adpcma_tagcam.sv
// Fully-associative byte cache: key compare, one-hot hit mux, flush and
// round-robin replacement with in-place update of duplicate keys.
module jt10_adpcma_tagcam
    import jt10_adpcma_rom_pkg::*;
#(
    parameter int ENTRIES = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [KEY_W-1:0]  lk_key,
    output logic              lk_hit,
    output logic [DATA_W-1:0] lk_data,
    input  logic [KEY_W-1:0]  pf_key,
    output logic              pf_hit,
    input  logic              wr_en,
    input  logic [KEY_W-1:0]  wr_key,
    input  logic [DATA_W-1:0] wr_data
);

    localparam int IW = $clog2(ENTRIES);

    logic [ENTRIES-1:0] valid;
    logic [KEY_W-1:0]   keys [ENTRIES];
    logic [DATA_W-1:0]  data [ENTRIES];
    logic [IW-1:0]      ptr;

    logic [ENTRIES-1:0] lk_vec;
    logic [ENTRIES-1:0] pf_vec;
    logic [ENTRIES-1:0] wr_vec;
    logic [IW-1:0]      wr_idx;
    logic               wr_dup;

    always_comb begin
        lk_vec = '0;
        pf_vec = '0;
        wr_vec = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            lk_vec[i] = valid[i] && (keys[i] == lk_key);
            pf_vec[i] = valid[i] && (keys[i] == pf_key);
            wr_vec[i] = valid[i] && (keys[i] == wr_key);
        end
    end

    // Keys are unique, so the hit vector is one-hot and an OR-mux is enough.
    always_comb begin
        lk_data = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            lk_data = lk_data | (data[i] & {DATA_W{lk_vec[i]}});
        end
    end

    assign lk_hit = |lk_vec;
    assign pf_hit = |pf_vec;

    always_comb begin
        wr_idx = ptr;
        wr_dup = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (wr_vec[i]) begin
                wr_idx = IW'(i);
                wr_dup = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            ptr   <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                keys[i] <= '0;
                data[i] <= '0;
            end
        end else if (flush) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
            keys[wr_idx]  <= wr_key;
            data[wr_idx]  <= wr_data;
            if (!wr_dup) begin
                ptr <= ptr + IW'(1);
            end
        end
    end

endmodule

// File: rtl/jt10_adpcma_rom_resp.sv
// ADPCM-A sample ROM responder: serves fixed-timing driver reads from a small
// cache, filling misses and next-byte prefetches from a variable-latency port.
//
// state | meaning
// IDLE  | no request outstanding; issues D first, then P
// REQ_D | demand fill in flight, waiting for mem_ack
// REQ_P | prefetch fill in flight, waiting for mem_ack
module jt10_adpcma_rom_resp
    import jt10_adpcma_rom_pkg::*;
#(
    parameter int               ENTRIES  = 8,
    parameter logic [KEY_W-1:0] BASE     = 24'h000000,
    parameter int               PREFETCH = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cen,
    input  logic [19:0]       addr,
    input  logic [3:0]        bank,
    input  logic              roe_n,
    input  logic              flush,
    output logic [DATA_W-1:0] dout,
    output logic [KEY_W-1:0]  mem_addr,
    output logic              mem_req,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_data,
    output logic              miss
);

    state_t           state;
    slot_t            slot_d;
    slot_t            slot_p;
    logic [KEY_W-1:0] req_key;
    logic             discard;

    logic [KEY_W-1:0]  key;
    logic [KEY_W-1:0]  next_key;
    logic              lookup;
    logic              fill_ok;
    logic              bypass;
    logic              hit;
    logic              d_issued;
    logic              pf_skip;
    logic              lk_hit;
    logic              pf_hit;
    logic [DATA_W-1:0] lk_data;

    assign key      = {bank, addr};
    assign next_key = req_key + KEY_W'(1);
    assign lookup   = cen && !roe_n;

    // A flush in this cycle or earlier in the transaction voids the fill.
    assign fill_ok  = mem_ack && (state != IDLE) && !discard && !flush;
    assign bypass   = fill_ok && (req_key == key);
    assign hit      = !flush && (bypass || lk_hit);

    // D counts as issued on the very edge IDLE launches it, so a miss cannot
    // overwrite the key that is already on mem_addr.
    assign d_issued = (state == REQ_D) || ((state == IDLE) && slot_d.valid && !flush);
    assign pf_skip  = pf_hit || (slot_d.valid && (slot_d.key == next_key));

    jt10_adpcma_tagcam #(
        .ENTRIES (ENTRIES)
    ) u_tagcam (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .lk_key  (key),
        .lk_hit  (lk_hit),
        .lk_data (lk_data),
        .pf_key  (next_key),
        .pf_hit  (pf_hit),
        .wr_en   (fill_ok),
        .wr_key  (req_key),
        .wr_data (mem_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            slot_d   <= '0;
            slot_p   <= '0;
            req_key  <= '0;
            discard  <= 1'b0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            dout     <= '0;
            miss     <= 1'b0;
        end else begin
            miss <= 1'b0;
            if (lookup) begin
                if (hit) begin
                    dout <= bypass ? mem_data : lk_data;
                end else begin
                    miss <= 1'b1;
                end
            end

            if (flush) begin
                slot_p.valid <= 1'b0;
                if (state != REQ_D) begin
                    slot_d.valid <= 1'b0;
                end
            end

            case (state)
                IDLE: begin
                    if (!flush) begin
                        if (slot_d.valid) begin
                            req_key  <= slot_d.key;
                            mem_addr <= BASE + slot_d.key;
                            mem_req  <= 1'b1;
                            state    <= REQ_D;
                        end else if (slot_p.valid) begin
                            req_key  <= slot_p.key;
                            mem_addr <= BASE + slot_p.key;
                            mem_req  <= 1'b1;
                            state    <= REQ_P;
                        end
                    end
                end
                REQ_D, REQ_P: begin
                    if (flush) begin
                        discard <= 1'b1;
                    end
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        discard <= 1'b0;
                        state   <= IDLE;
                        if (state == REQ_D) begin
                            slot_d.valid <= 1'b0;
                            if (fill_ok && (PREFETCH != 0) && !pf_skip) begin
                                slot_p.valid <= 1'b1;
                                slot_p.key   <= next_key;
                            end
                        end else begin
                            slot_p.valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase

            // Placed after the flush clear: a lookup alongside flush is a
            // post-flush miss and still records its key.
            if (lookup && !hit && !d_issued) begin
                slot_d.valid <= 1'b1;
                slot_d.key   <= key;
            end
        end
    end

endmodule

// File: doc/jt10_adpcma_rom_resp.md
Name: jt10_adpcma_rom_resp

Overview:
- Memory-side responder for the ADPCM-A sample ROM port: the other end of the YM2610 ADPCM-A fetch interface (addr/bank/roe_n out, datain back).
- Converts the fixed-timing ROM reads into requests to a variable-latency external memory (SDRAM arbiter port).
- Hides latency with a small fully-associative byte cache plus next-byte prefetch.
- Sits between the jt10 ADPCM-A driver and the board memory controller.

Parameters:
- ENTRIES, 8, number of cache entries (power of two, 2..16).
- BASE, 24'h000000, byte offset of the ADPCM-A region in external memory.
- PREFETCH, 1, enables sequential next-byte prefetch (0 disables it).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cen  in  1  666 kHz clock enable, same enable the driver uses.
- addr  in  20  byte address from the driver.
- bank  in  4  bank from the driver.
- roe_n  in  1  ROM output enable, active low.
- flush  in  1  invalidates all cache entries (ROM reload).
- dout  out  8  ROM data to the driver datain.
- mem_addr  out  24  external memory byte address.
- mem_req  out  1  request, held until acknowledged.
- mem_ack  in  1  one-cycle acknowledge; mem_data valid in the same cycle.
- mem_data  in  8  returned byte.
- miss  out  1  one-clk pulse when a lookup on cen misses.

Behaviour:
- Reset values:
  - dout=0, mem_req=0, mem_addr=0, miss=0.
  - All valid bits=0, replacement pointer=0, FSM=IDLE, no pending slots.
- Key: K={bank,addr} (24 bits). Physical address = BASE+K, wrapping mod 2^24.
- Lookup:
  - Happens on every clk edge with cen=1 and roe_n=0. No lookup when roe_n=1; dout holds its value.
  - Hit: dout <= entry data at that edge (latency 1 clk). The driver consumes it on its next cen.
  - Miss: dout holds its previous value, miss=1 for one clk, and K is placed in the demand slot.
- Fill bypass: if mem_ack returns data for key K in the same cycle as a lookup of K, treat it as a hit. dout <= mem_data and miss stays 0.
- Slots: one demand slot (D) and one prefetch slot (P), each holding a valid bit and a key.
  - A new miss overwrites D if D has not been issued yet.
  - If D has been issued, the new miss is dropped and miss still pulses.
- Prefetch: on a demand fill of K (PREFETCH=1), P <= K+1 with bank carry (24-bit increment). Skipped if K+1 is already cached or already in D.
- FSM states:
  - IDLE:
    - If D is valid: mem_addr <= BASE+D, mem_req <= 1, go to REQ_D.
    - Else if P is valid: mem_addr <= BASE+P, mem_req <= 1, go to REQ_P.
  - REQ_D / REQ_P: mem_req held high and mem_addr stable until mem_ack.
    - On mem_ack: mem_req <= 0, write the entry (valid=1, key, data), clear the issued slot, return to IDLE. Issuing from IDLE resumes on the next clk.
  - A prefetch in flight is never aborted. A demand arriving meanwhile waits in D.
- Entry write:
  - If the key is already present (duplicate), update that entry in place.
  - Otherwise write the entry at the replacement pointer, then pointer = pointer+1 mod ENTRIES.
- flush:
  - Clears all valid bits and P in one clk. D is also cleared unless already issued.
  - An in-flight request completes its handshake, but its data is discarded and no entry is written.
  - flush together with a lookup: the lookup sees the post-flush state, i.e. a miss.
- Simultaneous events:
  - A mem_ack write and a lookup in the same cycle: the write lands before the next cycle.
  - Two entries never hold the same key.
- mem_ack while in IDLE: ignored. This covers a late ack after reset.
- Reset mid-transaction: mem_req drops immediately (asynchronous).
- Transparency: if memory latency is at most 17 cen periods per miss, the driver sees correct data after the first miss of a new sample start.

Decomposition:
- Package jt10_adpcma_rom_pkg holds:
  - constants KEY_W=24, DATA_W=8;
  - the FSM state enum {IDLE, REQ_D, REQ_P};
  - the slot struct {valid, key}.
- Sub-module jt10_adpcma_tagcam: ENTRIES-way key compare, one-hot hit vector, data mux, valid/flush handling, and the round-robin write pointer.

Test Plan:
- Cold read: roe_n=0, K=24'h000100, 3-clk ack latency, mem_data=8'hA5.
  - miss pulses once.
  - mem_req=1 with mem_addr=BASE+24'h000100 until ack.
  - Next cen lookup gives dout=8'hA5.
  - A prefetch of 24'h000101 follows.
- Prefetch hit: after the cold read, K=24'h000101 on a later cen.
  - No miss pulse.
  - dout = prefetched byte one clk after cen.
- Bank carry: K=24'h0FFFFF filled, PREFETCH=1 → prefetch issues mem_addr=BASE+24'h100000.
- Thrash: ENTRIES=8, 9 distinct keys filled in sequence → the first key misses again; the other 8 hit.
- Flush during REQ_P: assert flush while mem_req=1.
  - The handshake completes.
  - A following lookup of the prefetched key misses.
  - Valid count stays 0 until the next fill.
- Same-cycle fill/lookup: schedule mem_ack with data 8'h3C on the exact cen edge that looks up the same key → dout=8'h3C, miss=0.
